// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared constants, types and bit-mixing helpers for the SHA-256 datapath.
//
// Contents:
//   WORDS_IN_CHUNK     number of 32-bit words in one 512-bit message block
//   WORDS_IN_SCHEDULE  number of words in the message schedule array
//   EXPANDED_WORDS     schedule words produced by expansion (64 - 16)
//   MsaExpanderState   state type of the message schedule expander
//   rightRotate32      32-bit rotate right
//   smallSigma0/1      the schedule mixing functions s0 and s1
// ---------------------------------------------------------------------------
package sha256_pkg;

    localparam int WORDS_IN_CHUNK    = 16;
    localparam int WORDS_IN_SCHEDULE = 64;
    localparam int EXPANDED_WORDS    = WORDS_IN_SCHEDULE - WORDS_IN_CHUNK;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        OUTPUT = 2'd2
    } MsaExpanderState;

    // Rotate right by a constant amount; callers pass 1..31.
    function automatic logic [31:0] rightRotate32(input logic [31:0] x,
                                                  input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] smallSigma0(input logic [31:0] x);
        return rightRotate32(x, 7) ^ rightRotate32(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] smallSigma1(input logic [31:0] x);
        return rightRotate32(x, 17) ^ rightRotate32(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/msa_expand_step.sv
// ---------------------------------------------------------------------------
// msa_expand_step
// Combinational computation of one SHA-256 message schedule word:
//   w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16]   (mod 2^32)
//
// Ports:
//   w_m2   in   32  w[t-2]
//   w_m7   in   32  w[t-7]
//   w_m15  in   32  w[t-15]
//   w_m16  in   32  w[t-16]
//   w_t    out  32  w[t]
// ---------------------------------------------------------------------------
module msa_expand_step
    import sha256_pkg::*;
(
    input  logic [31:0] w_m2,
    input  logic [31:0] w_m7,
    input  logic [31:0] w_m15,
    input  logic [31:0] w_m16,
    output logic [31:0] w_t
);

    assign w_t = smallSigma1(w_m2) + w_m7 + smallSigma0(w_m15) + w_m16;

endmodule

// File: rtl/msa_expander.sv
// ---------------------------------------------------------------------------
// msa_expander
// Accepts one 512-bit chunk (16 big-endian words), expands it into the full
// 64-word SHA-256 message schedule over 48/WORDS_PER_CYCLE cycles and then
// presents the whole schedule to the compressor on a valid/ready handshake.
// Only one chunk is in flight at a time.
//
// Parameters:
//   WORDS_PER_CYCLE  schedule words computed per EXPAND cycle; must divide 48
//                    and be at most 16 (1,2,3,4,6,8,12,16)
//
// Build option:
//   MSA_EXPANDER_BYTESWAP_EN  when defined, every chunk word is byte-reversed
//                             as it is accepted (little-endian upstream buffer)
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active low
//   chunk_rdy  out  1      block can accept a chunk (registered)
//   chunk_vld  in   1      chunk is valid
//   chunk      in   16x32  chunk words, chunk[0] first word of the block
//   w_rdy      in   1      compressor ready for a schedule
//   w_vld      out  1      schedule is valid (registered)
//   w          out  64x32  schedule, w[0..15] = chunk, w[16..63] = expansion
// ---------------------------------------------------------------------------
module msa_expander
    import sha256_pkg::*;
#(
    parameter int WORDS_PER_CYCLE = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    output logic                                 chunk_rdy,
    input  logic                                 chunk_vld,
    input  logic [WORDS_IN_CHUNK-1:0][31:0]      chunk,
    input  logic                                 w_rdy,
    output logic                                 w_vld,
    output logic [WORDS_IN_SCHEDULE-1:0][31:0]   w
);

    localparam int STEPS = EXPANDED_WORDS / WORDS_PER_CYCLE;
    localparam int CW    = $clog2(STEPS);
    localparam logic [CW-1:0] LAST_COUNT = CW'(STEPS - 1);

    if (WORDS_PER_CYCLE < 1 || WORDS_PER_CYCLE > WORDS_IN_CHUNK ||
        (EXPANDED_WORDS % WORDS_PER_CYCLE) != 0) begin : g_bad_param
        $error("msa_expander: WORDS_PER_CYCLE must divide 48 and be <= 16");
    end

    MsaExpanderState state;
    MsaExpanderState next_state;
    logic [CW-1:0]   count;
    logic            accept;
    logic [5:0]      base;

    logic [WORDS_IN_CHUNK-1:0][31:0]  load_words;
    logic [WORDS_PER_CYCLE-1:0][31:0] step_words;

    assign accept = (state == IDLE) && chunk_vld && chunk_rdy;

    // Index of the first word produced in the current EXPAND cycle.
    assign base = 6'(WORDS_IN_CHUNK + int'(count) * WORDS_PER_CYCLE);

    // Words as they are stored on accept; optionally byte-reversed.
    always_comb begin
        for (int i = 0; i < WORDS_IN_CHUNK; i++) begin
`ifdef MSA_EXPANDER_BYTESWAP_EN
            load_words[i] = {chunk[i][7:0], chunk[i][15:8],
                             chunk[i][23:16], chunk[i][31:24]};
`else
            load_words[i] = chunk[i];
`endif
        end
    end

    // Chain of step units. Taps that fall inside the current cycle's batch
    // come straight from the earlier step outputs rather than the register.
    for (genvar k = 0; k < WORDS_PER_CYCLE; k++) begin : g_step
        logic [31:0] tap2, tap7, tap15, tap16, wt;

        if (k >= 2) begin : g_t2_chain
            assign tap2 = g_step[k-2].wt;
        end else begin : g_t2_reg
            assign tap2 = w[base - 6'(2 - k)];
        end

        if (k >= 7) begin : g_t7_chain
            assign tap7 = g_step[k-7].wt;
        end else begin : g_t7_reg
            assign tap7 = w[base - 6'(7 - k)];
        end

        if (k >= 15) begin : g_t15_chain
            assign tap15 = g_step[k-15].wt;
        end else begin : g_t15_reg
            assign tap15 = w[base - 6'(15 - k)];
        end

        assign tap16 = w[base - 6'(16 - k)];

        msa_expand_step u_step (
            .w_m2  (tap2),
            .w_m7  (tap7),
            .w_m15 (tap15),
            .w_m16 (tap16),
            .w_t   (wt)
        );

        assign step_words[k] = wt;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; the spare encoding falls back to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)                 next_state = EXPAND;
            EXPAND:  if (count == LAST_COUNT)    next_state = OUTPUT;
            OUTPUT:  if (w_vld && w_rdy)         next_state = IDLE;
            default:                             next_state = IDLE;
        endcase
    end

    // Handshake flags are registered from the upcoming state, so chunk_rdy
    // drops on the accepting edge and w_vld appears with the OUTPUT state.
    // The schedule register loads the chunk on accept and then fills in
    // one batch of expanded words per EXPAND cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chunk_rdy <= 1'b0;
            w_vld     <= 1'b0;
            count     <= '0;
            w         <= '0;
        end else begin
            chunk_rdy <= (next_state == IDLE);
            w_vld     <= (next_state == OUTPUT);
            if (accept) begin
                for (int i = 0; i < WORDS_IN_CHUNK; i++) begin
                    w[i] <= load_words[i];
                end
                count <= '0;
            end else if (state == EXPAND) begin
                for (int k = 0; k < WORDS_PER_CYCLE; k++) begin
                    w[base + 6'(k)] <= step_words[k];
                end
                if (count != LAST_COUNT) begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_msa_expander.sv
// ---------------------------------------------------------------------------
// tb_msa_expander
// Self-checking bench for msa_expander. Known-answer vectors from a table,
// hand-written backpressure and reset sequences, then randomized back-to-back
// traffic checked against a software schedule model and a scoreboard queue.
// Build option MSA_EXPANDER_BYTESWAP_EN: the bench presents the chunk words
// byte-reversed on the bus so the expected schedules stay the same.
// ---------------------------------------------------------------------------
module tb_msa_expander #(
    parameter int WPC = 1
);

    typedef logic [15:0][31:0] chunk_t;
    typedef logic [63:0][31:0] sched_t;

    typedef struct {
        string       name;
        chunk_t      words;
        logic [31:0] exp16;
        logic [31:0] exp17;
        logic [31:0] exp18;
        logic [31:0] exp19;
    } vec_t;

    localparam int LATENCY     = 48 / WPC + 1;
    localparam int RAND_CYCLES = 3000;
    localparam int DRAIN       = 200;

    logic   clk;
    logic   rst;
    logic   chunk_rdy;
    logic   chunk_vld;
    chunk_t chunk;
    logic   w_rdy;
    logic   w_vld;
    sched_t w;

    int checks = 0;
    int errors = 0;

    msa_expander #(.WORDS_PER_CYCLE(WPC)) dut (
        .clk       (clk),
        .rst       (rst),
        .chunk_rdy (chunk_rdy),
        .chunk_vld (chunk_vld),
        .chunk     (chunk),
        .w_rdy     (w_rdy),
        .w_vld     (w_vld),
        .w         (w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule straight from the SHA-256 definition.
    function automatic sched_t modelSchedule(input chunk_t m);
        sched_t s;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                s[t] = m[t];
            end else begin
                s[t] = (rotr(s[t-2], 17) ^ rotr(s[t-2], 19) ^ (s[t-2] >> 10))
                     + s[t-7]
                     + (rotr(s[t-15], 7) ^ rotr(s[t-15], 18) ^ (s[t-15] >> 3))
                     + s[t-16];
            end
        end
        return s;
    endfunction

    // Bus encoding of a logical chunk for the current build.
    function automatic chunk_t toBus(input chunk_t m);
        chunk_t b;
        for (int i = 0; i < 16; i++) begin
`ifdef MSA_EXPANDER_BYTESWAP_EN
            b[i] = {m[i][7:0], m[i][15:8], m[i][23:16], m[i][31:24]};
`else
            b[i] = m[i];
`endif
        end
        return b;
    endfunction

    function automatic chunk_t randomChunk();
        chunk_t c;
        for (int i = 0; i < 16; i++) c[i] = $urandom;
        return c;
    endfunction

    function automatic int countDiffs(input sched_t a, input sched_t b);
        int n = 0;
        for (int i = 0; i < 64; i++) if (a[i] !== b[i]) n++;
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Called at a falling edge. Presents the chunk until it is taken; returns
    // at the falling edge right after the accepting rising edge.
    task automatic applyStimulus(input chunk_t words, output bit ok);
        ok = 1'b0;
        chunk     = toBus(words);
        chunk_vld = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (chunk_rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        chunk_vld = 1'b0;
        chunk     = randomChunk();
    endtask

    // Counts falling edges (the first one after accept is 1) until w_vld.
    task automatic waitValid(output int lat);
        lat = 1;
        while (!w_vld && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    vec_t   vectors[2];
    sched_t held;
    sched_t q[$];
    int     lat;
    bit     ok;

    initial begin
        chunk_t abc;
        chunk_t cur;
        int     accepted;
        int     delivered;
        int     cyc;
        int     acceptCyc;
        bit     pendingLat;

        abc = '0;
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;
        vectors[0] = '{"abc", abc, 32'h61626380, 32'h000F0000,
                       32'h7DA86405, 32'h600003C6};
        vectors[1] = '{"zero", chunk_t'('0), 32'h0, 32'h0, 32'h0, 32'h0};

        rst       = 1'b0;
        chunk_vld = 1'b0;
        w_rdy     = 1'b0;
        chunk     = '0;

        #2;
        checkOutput("reset_chunk_rdy", chunk_rdy, 0);
        checkOutput("reset_w_vld", w_vld, 0);
        checkOutput("reset_w_zero", countDiffs(w, sched_t'('0)), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("idle_chunk_rdy", chunk_rdy, 1);

        // Known-answer vectors with w_rdy held high.
        for (int i = 0; i < 2; i++) begin
            w_rdy = 1'b1;
            applyStimulus(vectors[i].words, ok);
            checkOutput({vectors[i].name, "_accept"}, ok, 1);
            waitValid(lat);
            checkOutput({vectors[i].name, "_latency"}, lat, LATENCY);
            checkOutput({vectors[i].name, "_w16"}, w[16], vectors[i].exp16);
            checkOutput({vectors[i].name, "_w17"}, w[17], vectors[i].exp17);
            checkOutput({vectors[i].name, "_w18"}, w[18], vectors[i].exp18);
            checkOutput({vectors[i].name, "_w19"}, w[19], vectors[i].exp19);
            checkOutput({vectors[i].name, "_schedule_diffs"},
                        countDiffs(w, modelSchedule(vectors[i].words)), 0);
            @(negedge clk);
            checkOutput({vectors[i].name, "_post_w_vld"}, w_vld, 0);
            checkOutput({vectors[i].name, "_post_chunk_rdy"}, chunk_rdy, 1);
        end

        // Backpressure: schedule must be held for 20 cycles.
        w_rdy = 1'b0;
        cur = randomChunk();
        applyStimulus(cur, ok);
        checkOutput("bp_accept", ok, 1);
        waitValid(lat);
        checkOutput("bp_latency", lat, LATENCY);
        checkOutput("bp_schedule_diffs", countDiffs(w, modelSchedule(cur)), 0);
        held = w;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checkOutput("bp_w_vld", w_vld, 1);
            checkOutput("bp_w_stable", countDiffs(w, held), 0);
            checkOutput("bp_chunk_rdy", chunk_rdy, 0);
        end
        w_rdy = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_w_vld", w_vld, 0);
        checkOutput("bp_release_chunk_rdy", chunk_rdy, 1);

        // Reset at EXPAND cycle 10 clears everything without a clock edge.
        applyStimulus(randomChunk(), ok);
        checkOutput("rst_exp_accept", ok, 1);
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_exp_w_vld", w_vld, 0);
        checkOutput("rst_exp_chunk_rdy", chunk_rdy, 0);
        checkOutput("rst_exp_w_zero", countDiffs(w, sched_t'('0)), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_exp_idle_chunk_rdy", chunk_rdy, 1);

        // Reset while a schedule is being presented.
        w_rdy = 1'b0;
        applyStimulus(randomChunk(), ok);
        waitValid(lat);
        checkOutput("rst_out_w_vld_before", w_vld, 1);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_out_w_vld", w_vld, 0);
        checkOutput("rst_out_chunk_rdy", chunk_rdy, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_out_idle_chunk_rdy", chunk_rdy, 1);
        w_rdy = 1'b1;
        cur = randomChunk();
        applyStimulus(cur, ok);
        waitValid(lat);
        checkOutput("rst_after_latency", lat, LATENCY);
        checkOutput("rst_after_schedule_diffs", countDiffs(w, modelSchedule(cur)), 0);
        @(negedge clk);

        // Randomized back-to-back traffic against a scoreboard.
        accepted   = 0;
        delivered  = 0;
        cyc        = 0;
        acceptCyc  = 0;
        pendingLat = 1'b0;
        for (int c = 0; c < RAND_CYCLES + DRAIN; c++) begin
            @(negedge clk);
            cyc++;
            if (w_vld && pendingLat) begin
                checkOutput("rand_latency", cyc - acceptCyc, LATENCY);
                pendingLat = 1'b0;
            end
            cur = randomChunk();
            chunk = toBus(cur);
            if (c < RAND_CYCLES) begin
                chunk_vld = ($urandom_range(0, 3) != 0);
                w_rdy     = ($urandom_range(0, 1) != 0);
            end else begin
                chunk_vld = 1'b0;
                w_rdy     = 1'b1;
            end
            if (chunk_vld && chunk_rdy) begin
                q.push_back(modelSchedule(cur));
                acceptCyc  = cyc;
                pendingLat = 1'b1;
                accepted++;
            end
            if (w_vld && w_rdy) begin
                if (q.size() == 0) begin
                    checkOutput("rand_unexpected_schedule", 1, 0);
                end else begin
                    checkOutput("rand_schedule_diffs", countDiffs(w, q.pop_front()), 0);
                end
                delivered++;
            end
        end
        checkOutput("rand_queue_empty", q.size(), 0);
        checkOutput("rand_delivered_count", delivered, accepted);
        checkOutput("rand_progress", (delivered >= 3), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msa_expander.md
Name: msa_expander

Overview:
Producer side of the compressor's `w` interface. It accepts one 512-bit chunk of 16 big-endian 32-bit words and expands it iteratively into the 64-word SHA-256 message schedule array. It then presents all 64 words on a valid/ready handshake to the downstream compressor.
- Sits between the chunk padder/buffer and the compressor.
- One chunk is in flight at a time.

Parameters:
- WORDS_PER_CYCLE, 1, number of schedule words computed per EXPAND cycle. Legal values are 1, 2, 3, 4, 6, 8, 12, 16, i.e. 48 % WORDS_PER_CYCLE == 0. Any other value is an elaboration error.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- chunk_rdy  out  1  block can accept a chunk.
- chunk_vld  in  1  chunk is valid.
- chunk  in  16x32  chunk words; chunk[0] is the first word of the message block.
- w_rdy  in  1  compressor ready for a schedule.
- w_vld  out  1  schedule is valid.
- w  out  64x32  expanded schedule; w[0..15] = chunk, w[16..63] = expansion.

Behaviour:
- Reset (rst=0, async): state=IDLE, chunk_rdy=0, w_vld=0, round counter=0, w register=0. Outputs follow reset immediately, without waiting for a clock edge.
- States and transitions:
  - IDLE -> EXPAND when chunk_vld & chunk_rdy.
  - EXPAND -> OUTPUT when the counter reaches 48/WORDS_PER_CYCLE - 1 at a clock edge.
  - OUTPUT -> IDLE when w_vld & w_rdy.
- chunk_rdy is registered. It is 1 only while in IDLE, and drops in the same edge that accepts a chunk.
- Accept: at the handshake edge, w[0..15] <= chunk and counter <= 0.
- EXPAND: each cycle computes words t = 16 + counter*WORDS_PER_CYCLE + k, for k = 0..WORDS_PER_CYCLE-1.
  - Formula: w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-16+1]) + w[t-16], all mod 2^32.
  - s0(x) = ror7 ^ ror18 ^ shr3.
  - s1(x) = ror17 ^ ror19 ^ shr10.
  - Within a cycle, words chain combinationally: word k may use word k-2 computed in the same cycle.
- Latency: w_vld rises exactly 48/WORDS_PER_CYCLE + 1 cycles after the accept edge (49 cycles for WORDS_PER_CYCLE=1).
- OUTPUT:
  - w_vld is held at 1 and w is held stable until w_rdy.
  - w_rdy may be 1 before w_vld; the handshake then completes on the first OUTPUT edge.
  - After the handshake: w_vld=0 and chunk_rdy=1 on the next edge.
  - Minimum chunk period is latency + 1 cycles.
- chunk_vld while not ready is ignored; chunk contents are sampled only on the handshake edge.
- w contents are don't-care while w_vld=0.
- w_rdy is ignored outside OUTPUT.
- Reset mid-EXPAND or mid-OUTPUT discards the in-flight chunk. No partial schedule is ever presented.
- Counter width is $clog2(48/WORDS_PER_CYCLE). The counter never wraps in use; it is cleared on every accept.
- An unreachable state encoding returns to IDLE.

Optional Feature:
- MSA_EXPANDER_BYTESWAP_EN:
  - Defined: each chunk word is byte-reversed at the accept edge ({b0,b1,b2,b3} -> {b3,b2,b1,b0}) before storage and expansion, for a little-endian upstream buffer.
  - Undefined: words are stored unmodified.
  - Latency is identical in both builds.

Decomposition:
- Additions to sha256_pkg:
  - WORDS_IN_CHUNK=16 and WORDS_IN_SCHEDULE=64.
  - Functions smallSigma0/smallSigma1, built on the existing rightRotate32.
  - MsaExpanderState typedef: IDLE, EXPAND, OUTPUT.
- Sub-module msa_expand_step: combinational, inputs w[t-2], w[t-7], w[t-15], w[t-16], output w[t]. It is instantiated WORDS_PER_CYCLE times in a chain.

Test Plan:
- "abc" padded chunk (word0=0x61626380, words1-14=0, word15=0x00000018), w_rdy held 1, WORDS_PER_CYCLE=1 -> w_vld rises 49 cycles after accept, with w[16]=0x61626380, w[17]=0x000F0000, w[18]=0x7DA86405, w[19]=0x600003C6. All 64 words must match the software model.
- All-zero chunk -> all 64 w words = 0; chunk_rdy returns 1 on the edge after the handshake.
- Backpressure: w_rdy=0 for 20 cycles in OUTPUT -> w_vld stays 1, w unchanged every cycle, chunk_rdy stays 0. Raising w_rdy completes the handshake in 1 edge.
- Reset pulse (rst=0) at EXPAND cycle 10 -> w_vld and chunk_rdy are 0 asynchronously. After release: IDLE, chunk_rdy=1, and the next chunk yields a correct schedule.
- Back-to-back random chunks with random chunk_vld/w_rdy, under WORDS_PER_CYCLE = 1, 4 and 16 -> every schedule matches the model. Latency = 48/WORDS_PER_CYCLE + 1. No chunk is dropped or duplicated.
- MSA_EXPANDER_BYTESWAP_EN defined, chunk word0=0x80636261, word15=0x18000000 -> identical "abc" schedule to the first test.
